// File: rtl/fp_minmax_reduce.sv
`default_nettype none
// ============================================================================
// Module   : fp_minmax_reduce
// Brief    : Walks one binary64 min/max compare over a stream of N operands
//            and returns the winning value, its stream index and a sticky
//            NaN indication on a valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fp_minmax_reduce #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_start,
  input  logic [CNT_WIDTH-1:0]  in_len,
  input  logic                  in_ctrl_minmax,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_res_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [CNT_WIDTH-1:0]  out_index,
  output logic                  out_nan,
  output logic                  out_busy
);

  // binary64 field positions; only DATA_WIDTH = 64 is meaningful
  localparam int unsigned SIGN_BIT = DATA_WIDTH - 1;
  localparam int unsigned EXP_MSB  = DATA_WIDTH - 2;
  localparam int unsigned EXP_LSB  = 52;
  localparam int unsigned MAN_MSB  = 51;

  // canonical quiet NaN reported whenever any operand was NaN
  localparam logic [DATA_WIDTH-1:0] C_CANON_NAN = DATA_WIDTH'(64'h7FF8000000000000);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  state_e                  state_q,  state_d;
  logic [CNT_WIDTH-1:0]    len_q,    len_d;
  logic                    mode_q,   mode_d;
  logic [CNT_WIDTH-1:0]    cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_WIDTH-1:0]    idx_q,    idx_d;
  logic                    nan_q,    nan_d;

  logic                    w_xfer;
  logic                    w_in_nan;
  logic                    w_new_sign;
  logic                    w_acc_sign;
  logic [DATA_WIDTH-2:0]   w_new_mag;
  logic [DATA_WIDTH-2:0]   w_acc_mag;
  logic                    w_new_gt;
  logic                    w_new_lt;
  logic                    w_new_wins;
  logic [CNT_WIDTH-1:0]    w_cnt_inc;

  // Single shared compare: sign-magnitude ordering with -0 < +0; bit-identical
  // operands are neither greater nor less, so ties keep the accumulator.
  always_comb begin
    w_xfer     = in_valid && (state_q == ST_ACCUM);
    w_in_nan   = (&in_data[EXP_MSB:EXP_LSB]) && (|in_data[MAN_MSB:0]);
    w_new_sign = in_data[SIGN_BIT];
    w_acc_sign = acc_q[SIGN_BIT];
    w_new_mag  = in_data[DATA_WIDTH-2:0];
    w_acc_mag  = acc_q[DATA_WIDTH-2:0];
    if (w_new_sign != w_acc_sign) begin
      w_new_gt = !w_new_sign;
      w_new_lt = w_new_sign;
    end else if (w_new_sign) begin
      w_new_gt = w_new_mag < w_acc_mag;
      w_new_lt = w_new_mag > w_acc_mag;
    end else begin
      w_new_gt = w_new_mag > w_acc_mag;
      w_new_lt = w_new_mag < w_acc_mag;
    end
    w_new_wins = mode_q ? w_new_gt : w_new_lt;
    w_cnt_inc  = cnt_q + CNT_WIDTH'(1);
  end

  // Next-state and datapath update; everything holds unless a branch says otherwise.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    nan_d   = nan_q;
    case (state_q)
      ST_IDLE: begin
        if (in_start && (in_len != '0)) begin
          len_d   = in_len;
          mode_d  = in_ctrl_minmax;
          cnt_d   = '0;
          nan_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_xfer) begin
          cnt_d = w_cnt_inc;
          if (w_in_nan) begin
            // index freezes on the first NaN; later operands cannot move it
            if (!nan_q) begin
              idx_d = cnt_q;
            end
            nan_d = 1'b1;
          end else if (!nan_q && ((cnt_q == '0) || w_new_wins)) begin
            acc_d = in_data;
            idx_d = cnt_q;
          end
          if (w_cnt_inc == len_q) begin
            state_d = ST_RESULT;
          end
        end
      end
      ST_RESULT: begin
        if (in_res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial reduction.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      nan_q   <= nan_d;
    end
  end

  // Outputs come straight from registered state, so they are glitch-free and
  // naturally stable while the result waits for the consumer.
  always_comb begin
    out_ready  = (state_q == ST_ACCUM);
    out_valid  = (state_q == ST_RESULT);
    out_busy   = (state_q != ST_IDLE);
    out_result = nan_q ? C_CANON_NAN : acc_q;
    out_index  = idx_q;
    out_nan    = nan_q;
  end

endmodule
`default_nettype wire
